// File: rtl/seg7_scan_driver_if.sv
// seg7_scan_driver_if
//   Bundles the scan driver's functional signals so the driver and its
//   environment connect through a single port.
//   Inputs to the driver (master -> slave):
//     en        scan enable, 0 = display dark and scan parked
//     data0..3  hex value per digit, digit 0 is rightmost
//     dp_in     decimal point request per digit, active-high
//     blank_lz  1 = suppress leading zeros
//   Outputs from the driver (slave -> master):
//     sel        index of the digit whose slot is being shown
//     an         anode enables, active-low
//     seg        segments {g,f,e,d,c,b,a}, active-low
//     dp         decimal point, active-low
//     frame_tick one-cycle pulse at the end of digit 3's slot
interface seg7_scan_driver_if;
  logic       en;
  logic [3:0] data0;
  logic [3:0] data1;
  logic [3:0] data2;
  logic [3:0] data3;
  logic [3:0] dp_in;
  logic       blank_lz;
  logic [1:0] sel;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame_tick;

  modport master (
    output en, data0, data1, data2, data3, dp_in, blank_lz,
    input  sel, an, seg, dp, frame_tick
  );

  modport slave (
    input  en, data0, data1, data2, data3, dp_in, blank_lz,
    output sel, an, seg, dp, frame_tick
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
//   Autonomous time-multiplexed scan for a 4-digit common-anode 7-segment
//   display. Each digit owns a slot of REFRESH_DIV cycles; the first
//   BLANK_CYCLES of every slot keep all anodes off to avoid ghosting. The
//   digit values, decimal points and the leading-zero flag are frozen once
//   per frame so a display never shows a mix of old and new values.
//   Ports:
//     clk  system clock
//     rst  synchronous reset, active-high
//     bus  seg7_scan_driver_if.slave (en, data0..3, dp_in, blank_lz in;
//          sel, an, seg, dp, frame_tick out). All outputs are registered
//          and lag the slot counter by one cycle.
module seg7_scan_driver #(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input logic               clk,
  input logic               rst,
  seg7_scan_driver_if.slave bus
);

  localparam int            CW       = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      idx_q, idx_d;
  logic [3:0][3:0] snap_q, snap_d;
  logic [3:0]      snap_dp_q, snap_dp_d;
  logic            snap_lz_q, snap_lz_d;

  logic [1:0]      sel_q, sel_d;
  logic [3:0]      an_q, an_d;
  logic [6:0]      seg_q, seg_d;
  logic            dp_q, dp_d;
  logic            tick_q, tick_d;

  logic            capture;
  logic            cnt_wrap;
  logic            blank_phase;
  logic [3:0]      is_zero;
  logic [3:0]      lz_blank;

  // With no gap the compare would be against zero and always false.
  generate
    if (BLANK_CYCLES == 0) begin : g_no_gap
      assign blank_phase = 1'b0;
    end else begin : g_gap
      assign blank_phase = (cnt_q < CW'(BLANK_CYCLES));
    end
  endgenerate

  always_comb begin
    capture   = bus.en && (idx_q == 2'd0) && (cnt_q == '0);
    cnt_wrap  = (cnt_q == CNT_LAST);

    // The snapshot is bypassed in the capture cycle itself so that a
    // zero-gap configuration shows the fresh values on digit 0 right away.
    snap_d    = capture ? {bus.data3, bus.data2, bus.data1, bus.data0} : snap_q;
    snap_dp_d = capture ? bus.dp_in : snap_dp_q;
    snap_lz_d = capture ? bus.blank_lz : snap_lz_q;

    is_zero = '0;
    for (int i = 0; i < 4; i++) begin
      is_zero[i] = (snap_d[i] == 4'h0);
    end

    // A zero is leading only if every digit to its left is zero too; a
    // digit carrying a decimal point always stays visible.
    lz_blank    = '0;
    lz_blank[3] = snap_lz_d & is_zero[3] & ~snap_dp_d[3];
    lz_blank[2] = snap_lz_d & is_zero[3] & is_zero[2] & ~snap_dp_d[2];
    lz_blank[1] = snap_lz_d & is_zero[3] & is_zero[2] & is_zero[1] & ~snap_dp_d[1];

    cnt_d  = '0;
    idx_d  = 2'd0;
    sel_d  = 2'd0;
    an_d   = 4'hF;
    seg_d  = 7'h7F;
    dp_d   = 1'b1;
    tick_d = 1'b0;

    if (bus.en) begin
      cnt_d  = cnt_wrap ? '0 : cnt_q + CW'(1);
      idx_d  = cnt_wrap ? idx_q + 2'd1 : idx_q;
      sel_d  = idx_q;
      tick_d = (idx_q == 2'd3) && cnt_wrap;
      if (!blank_phase) begin
        an_d  = ~(4'b0001 << idx_q);
        seg_d = lz_blank[idx_q] ? 7'h7F : hex_to_seg(snap_d[idx_q]);
        dp_d  = ~snap_dp_d[idx_q];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      idx_q     <= 2'd0;
      snap_q    <= '0;
      snap_dp_q <= 4'h0;
      snap_lz_q <= 1'b0;
      sel_q     <= 2'd0;
      an_q      <= 4'hF;
      seg_q     <= 7'h7F;
      dp_q      <= 1'b1;
      tick_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      snap_q    <= snap_d;
      snap_dp_q <= snap_dp_d;
      snap_lz_q <= snap_lz_d;
      sel_q     <= sel_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
      tick_q    <= tick_d;
    end
  end

  assign bus.sel        = sel_q;
  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.frame_tick = tick_q;

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Time-multiplexed scan controller for a 4-digit common-anode 7-segment display.
- Sits downstream of the 4-to-1 hex digit mux / 7-seg decoder stage and replaces its manual select input with an autonomous digit scan.
- Generates the digit select, the per-digit anode enables, the registered segment pattern and decimal point.
- Snapshots the four digit values once per frame (no tearing), inserts an anti-ghosting blank gap between digits, and optionally suppresses leading zeros.

Parameters:
- REFRESH_DIV, 50000: clock cycles per digit slot (blank gap included); must be ≥ 2.
- BLANK_CYCLES, 16: cycles at the start of each slot with all anodes off; 0 ≤ BLANK_CYCLES < REFRESH_DIV.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- en  input  1  scan enable; 0 = display dark, scan parked
- data0  input  4  hex value, digit 0 (rightmost)
- data1  input  4  hex value, digit 1
- data2  input  4  hex value, digit 2
- data3  input  4  hex value, digit 3 (leftmost)
- dp_in  input  4  decimal point request per digit, bit i = digit i, active-high
- blank_lz  input  1  1 = suppress leading zeros
- sel  output  2  index of the digit currently in its slot
- an  output  4  anode enables, active-low, one-hot-low when lit
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low
- dp  output  1  decimal point, active-low
- frame_tick  output  1  one-cycle pulse at the end of digit 3's slot

Behaviour:
- One clock, synchronous active-high reset; every output is registered.
- Reset values:
  - an = 4'hF, seg = 7'h7F, dp = 1, sel = 0, frame_tick = 0.
  - Slot counter = 0, digit index = 0, snapshot registers = 0.
- Slot counter cnt runs 0..REFRESH_DIV-1 and wraps; the digit index increments on wrap, 3 → 0.
- sel always equals the digit index.
- Per slot, with all outputs lagging cnt by exactly one cycle:
  - BLANK phase (cnt < BLANK_CYCLES): an = 4'hF, seg = 7'h7F, dp = 1.
  - SHOW phase (remaining REFRESH_DIV-BLANK_CYCLES cycles): an bit[sel] = 0, other bits 1; seg = decode of snapshot[sel]; dp = ~dp_in_snapshot[sel].
- Snapshot:
  - data0..3, dp_in and blank_lz are all captured in the cycle where the digit index is 0 and cnt = 0.
  - Input changes mid-frame are not visible until the next frame.
- Decode, active-low {g..a}:
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000
  - 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000
  - 8 = 0000000, 9 = 0010000, A = 0001000, b = 0000011
  - C = 1000110, d = 0100001, E = 0000110, F = 0001110
- Leading-zero blanking, when the blank_lz snapshot = 1:
  - Digit 3 is blank if it is 0.
  - Digit 2 is blank if it and digit 3 are both 0.
  - Digit 1 is blank if digits 1–3 are all 0.
  - Digit 0 is never blanked.
  - A blanked digit has seg = 7'h7F and its anode is still driven low.
  - A digit whose dp bit is set is never blanked.
- frame_tick = 1 for exactly one cycle, aligned with the last SHOW cycle of digit 3.
- en = 0:
  - Next cycle an = 4'hF, seg = 7'h7F, dp = 1, frame_tick = 0.
  - cnt and digit index reset to 0.
  - When en returns to 1, the first cycle starts a fresh frame, taking a new snapshot.
- rst mid-slot: next cycle all outputs and state at reset values; the scan restarts from digit 0 with a blank gap.
- BLANK_CYCLES = 0: no gap; consecutive anodes switch on the same edge.
- Never more than one anode low in any cycle.

Test Plan (REFRESH_DIV = 8, BLANK_CYCLES = 2 unless noted):
- Reset and gap timing:
  - Stimulus: rst for 3 cycles, then en = 1, data3..0 = b,A,3,4, dp_in = 0, blank_lz = 0.
  - Response: an = 1111 for 2 cycles then 1110 for 6 cycles with seg = 0011001 (4), dp = 1, sel = 0.
  - Following slots: 1101/0110000 (3), 1011/0001000 (A), 0111/0000011 (b).
- Frame tick and wrap:
  - Stimulus: continuous run from the previous case.
  - Response: frame_tick high for exactly 1 cycle every 32 cycles, on the last lit cycle of an = 0111; sel wraps 3 → 0.
- Snapshot:
  - Stimulus: change data2 from A to 5 while sel = 1.
  - Response: digit 2 still shows 0001000 (A) in this frame; 0010010 (5) appears in the next frame.
- Leading-zero blanking:
  - Stimulus: data3..0 = 0,0,0,7, blank_lz = 1.
  - Response: digits 3, 2, 1 have seg = 1111111 with their anodes still low; digit 0 shows 1111000.
  - Stimulus: data3..0 = 0,0,0,0.
  - Response: digit 0 shows 1000000.
  - Stimulus: dp_in = 0100.
  - Response: digit 2 shows seg = 1000000 with dp = 0.
- Enable and reset mid-slot:
  - Stimulus: drop en during the SHOW phase of digit 2.
  - Response: an = 1111 next cycle.
  - Stimulus: re-raise en.
  - Response: 2 blank cycles, then an = 1110.
  - Stimulus: pulse rst mid-slot.
  - Response: same restart from digit 0.
- No-gap configuration:
  - Stimulus: BLANK_CYCLES = 0.
  - Response: an steps 1110 → 1101 on a single edge; an is never 1111 while en = 1; never more than one anode low.
